// File: rtl/ysyx_23060061_idu_pkg.sv
// Shared decode constants for the ysyx_23060061 IDU: opcodes, fixed system encodings,
// instruction-type / ALU-op / writeback / memory encodings and the decoded control bundle.
// Ports: none (package).
package ysyx_23060061_idu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // TYPE_NONE is what an empty queue or an illegal entry presents.
  typedef enum logic [2:0] {
    TYPE_NONE = 3'd0, TYPE_R = 3'd1, TYPE_I = 3'd2, TYPE_S = 3'd3,
    TYPE_B = 3'd4, TYPE_U = 3'd5, TYPE_J = 3'd6
  } inst_type_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10, ALU_ADDCLR = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10, WB_CSR = 2'b11} wb_sel_e;
  typedef enum logic [1:0] {MEM_IDLE = 2'b00, MEM_WRITE = 2'b01, MEM_READ = 2'b10} mem_rw_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef struct packed {
    inst_type_e inst_type;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    mem_rw_e    mem_rw;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       branch;
    logic [2:0] br_cond;
    logic       jump;
    logic       alu_a_sel;
    logic       alu_b_sel;
    alu_op_e    alu_op;
    wb_sel_e    wb_sel;
    logic       ebreak;
    logic       ecall;
    logic       mret;
    logic       illegal;
  } ctrl_t;

  // Shared funct3 -> ALU op map for OP and OP-IMM; alt selects SUB/SRA.
  function automatic alu_op_e alu_op_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060061_inst_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Latency: a pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: push_rdy = !full (no path from pop_rdy); flush beats push and pop.
// Ports: clk/rst_n, flush, push_vld/push_rdy/push_dat, pop_vld/pop_rdy/pop_dat, count.
module ysyx_23060061_inst_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push_vld,
  output logic                       push_rdy,
  input  logic [WIDTH-1:0]           push_dat,
  output logic                       pop_vld,
  input  logic                       pop_rdy,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign push_rdy = (cnt_q != CW'(DEPTH));
  assign pop_vld  = (cnt_q != '0);
  assign pop_dat  = mem_q[rd_ptr_q];
  assign count    = cnt_q;
  assign push     = push_vld && push_rdy && !flush;
  assign pop      = pop_vld && pop_rdy && !flush;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/ysyx_23060061_idu.sv
// Instruction decode unit: queues {inst, pc} from the IFU and decodes the head entry (RV32I/E).
// Latency: one cycle from accept to out_valid on an empty queue; one instruction per cycle streaming.
// Backpressure: in_ready = queue not full; head outputs hold while out_valid && !out_ready.
// Optional macro YSYX_23060061_ZICSR_EN: decodes CSR ops (wb_sel 11), ECALL and MRET.
// Ports: clk/rst_n/flush, in_* (IFU handshake), out_* (decoded head to EXU), count (occupancy).
module ysyx_23060061_idu
  import ysyx_23060061_idu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int NREG       = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_inst,
  input  logic [XLEN-1:0]             in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_pc,
  output logic [2:0]                  out_inst_type,
  output logic [4:0]                  out_rs1,
  output logic [4:0]                  out_rs2,
  output logic [4:0]                  out_rd,
  output logic [XLEN-1:0]             out_imm,
  output logic                        out_reg_write,
  output logic [1:0]                  out_mem_rw,
  output logic [1:0]                  out_mem_size,
  output logic                        out_mem_unsigned,
  output logic                        out_branch,
  output logic [2:0]                  out_br_cond,
  output logic                        out_jump,
  output logic                        out_alu_a_sel,
  output logic                        out_alu_b_sel,
  output logic [3:0]                  out_alu_op,
  output logic [1:0]                  out_wb_sel,
  output logic                        out_ebreak,
  output logic                        out_ecall,
  output logic                        out_mret,
  output logic                        out_illegal,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  logic [31+XLEN:0] head_dat;
  logic [31:0]      inst;
  logic [XLEN-1:0]  pc;

  ysyx_23060061_inst_fifo #(.WIDTH(32 + XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_vld(in_valid), .push_rdy(in_ready), .push_dat({in_inst, in_pc}),
    .pop_vld(out_valid), .pop_rdy(out_ready), .pop_dat(head_dat), .count(count)
  );

  assign {inst, pc} = head_dat;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  assign opc = inst[6:0];
  assign rd  = inst[11:7];
  assign f3  = inst[14:12];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign f7  = inst[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  ctrl_t           c, o;
  logic [XLEN-1:0] imm;
  // use_*: field is a register the instruction reads/writes (routed out and range-checked).
  logic            use1, use2, used, chk1, ill;

  always_comb begin
    c    = '0;
    imm  = '0;
    use1 = 1'b0;
    use2 = 1'b0;
    used = 1'b0;
    chk1 = 1'b1;
    ill  = 1'b0;
    case (opc)
      OP_LUI: begin
        c.inst_type = TYPE_U; used = 1'b1; imm = imm_u;
        c.alu_b_sel = 1'b1; c.alu_op = ALU_PASSB;
      end
      OP_AUIPC: begin
        c.inst_type = TYPE_U; used = 1'b1; imm = imm_u;
        c.alu_a_sel = 1'b1; c.alu_b_sel = 1'b1; c.alu_op = ALU_ADD;
      end
      OP_JAL: begin
        c.inst_type = TYPE_J; used = 1'b1; imm = imm_j; c.jump = 1'b1;
        c.alu_a_sel = 1'b1; c.alu_b_sel = 1'b1; c.alu_op = ALU_ADD; c.wb_sel = WB_PC4;
      end
      OP_JALR: begin
        ill = (f3 != 3'b000);
        c.inst_type = TYPE_I; use1 = 1'b1; used = 1'b1; imm = imm_i; c.jump = 1'b1;
        c.alu_b_sel = 1'b1; c.alu_op = ALU_ADDCLR; c.wb_sel = WB_PC4;
      end
      OP_BRANCH: begin
        ill = (f3[2:1] == 2'b01);
        c.inst_type = TYPE_B; use1 = 1'b1; use2 = 1'b1; imm = imm_b;
        c.branch = 1'b1; c.br_cond = f3; c.alu_op = ALU_SUB;
      end
      OP_LOAD: begin
        ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        c.inst_type = TYPE_I; use1 = 1'b1; used = 1'b1; imm = imm_i;
        c.alu_b_sel = 1'b1; c.mem_rw = MEM_READ; c.mem_size = f3[1:0];
        c.mem_unsigned = f3[2]; c.wb_sel = WB_MEM;
      end
      OP_STORE: begin
        ill = (f3 > 3'b010);
        c.inst_type = TYPE_S; use1 = 1'b1; use2 = 1'b1; imm = imm_s;
        c.alu_b_sel = 1'b1; c.mem_rw = MEM_WRITE; c.mem_size = f3[1:0];
      end
      OP_IMM: begin
        // Shift-immediates reuse funct7 as an encoding qualifier.
        ill = ((f3 == 3'b001) && (f7 != 7'h00)) ||
              ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
        c.inst_type = TYPE_I; use1 = 1'b1; used = 1'b1; imm = imm_i;
        c.alu_b_sel = 1'b1; c.alu_op = alu_op_of(f3, (f3 == 3'b101) && f7[5]);
      end
      OP_REG: begin
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
        c.inst_type = TYPE_R; use1 = 1'b1; use2 = 1'b1; used = 1'b1;
        c.alu_op = alu_op_of(f3, f7[5]);
      end
      OP_FENCE: begin
        // FENCE is an ordering no-op for this in-order core.
        ill = (f3 != 3'b000);
        c.inst_type = TYPE_I;
      end
      OP_SYSTEM: begin
        c.inst_type = TYPE_I;
        if (inst == INST_EBREAK) c.ebreak = 1'b1;
`ifdef YSYX_23060061_ZICSR_EN
        else if (inst == INST_ECALL) c.ecall = 1'b1;
        else if (inst == INST_MRET)  c.mret  = 1'b1;
        else if (f3[1:0] != 2'b00) begin
          // Immediate CSR forms carry zimm in the rs1 field: route it but skip the range check.
          use1 = 1'b1; chk1 = !f3[2]; used = 1'b1; imm = imm_i; c.wb_sel = WB_CSR;
        end
`endif
        else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase

    ill = ill || (use1 && chk1 && ({1'b0, rs1} >= 6'(NREG))) ||
          (use2 && ({1'b0, rs2} >= 6'(NREG))) || (used && ({1'b0, rd} >= 6'(NREG)));

    c.rs1       = use1 ? rs1 : 5'd0;
    c.rs2       = use2 ? rs2 : 5'd0;
    c.rd        = used ? rd  : 5'd0;
    c.reg_write = used && (rd != 5'd0);

    if (ill) begin
      c         = '0;
      c.illegal = 1'b1;
      imm       = '0;
    end
  end

  assign o = out_valid ? c : '0;

  assign out_pc           = out_valid ? pc  : '0;
  assign out_imm          = out_valid ? imm : '0;
  assign out_inst_type    = o.inst_type;
  assign out_rs1          = o.rs1;
  assign out_rs2          = o.rs2;
  assign out_rd           = o.rd;
  assign out_reg_write    = o.reg_write;
  assign out_mem_rw       = o.mem_rw;
  assign out_mem_size     = o.mem_size;
  assign out_mem_unsigned = o.mem_unsigned;
  assign out_branch       = o.branch;
  assign out_br_cond      = o.br_cond;
  assign out_jump         = o.jump;
  assign out_alu_a_sel    = o.alu_a_sel;
  assign out_alu_b_sel    = o.alu_b_sel;
  assign out_alu_op       = o.alu_op;
  assign out_wb_sel       = o.wb_sel;
  assign out_ebreak       = o.ebreak;
  assign out_ecall        = o.ecall;
  assign out_mret         = o.mret;
  assign out_illegal      = o.illegal;
endmodule

// File: tb/tb_ysyx_23060061_idu.sv
module tb_ysyx_23060061_idu;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  // Main instance (NREG=32).
  logic        in_ready, out_valid, out_reg_write, out_mem_unsigned, out_branch, out_jump;
  logic        out_alu_a_sel, out_alu_b_sel, out_ebreak, out_ecall, out_mret, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [2:0]  out_inst_type, out_br_cond;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [1:0]  out_mem_rw, out_mem_size, out_wb_sel;
  logic [3:0]  out_alu_op;
  logic [1:0]  count;

  // RV32E instance (NREG=16), fed the same stream.
  logic        e_in_ready, e_out_valid, e_reg_write, e_mem_unsigned, e_branch, e_jump;
  logic        e_a_sel, e_b_sel, e_ebreak, e_ecall, e_mret, e_illegal;
  logic [31:0] e_pc, e_imm;
  logic [2:0]  e_inst_type, e_br_cond;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [1:0]  e_mem_rw, e_mem_size, e_wb_sel;
  logic [3:0]  e_alu_op;
  logic [1:0]  e_count;

  int n_cmp = 0;
  int n_err = 0;

`ifdef YSYX_23060061_ZICSR_EN
  localparam bit ZICSR = 1'b1;
`else
  localparam bit ZICSR = 1'b0;
`endif

  always #5 clk = ~clk;

  ysyx_23060061_idu #(.XLEN(32), .FIFO_DEPTH(2), .NREG(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst_type(out_inst_type), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_reg_write(out_reg_write), .out_mem_rw(out_mem_rw),
    .out_mem_size(out_mem_size), .out_mem_unsigned(out_mem_unsigned), .out_branch(out_branch),
    .out_br_cond(out_br_cond), .out_jump(out_jump), .out_alu_a_sel(out_alu_a_sel),
    .out_alu_b_sel(out_alu_b_sel), .out_alu_op(out_alu_op), .out_wb_sel(out_wb_sel),
    .out_ebreak(out_ebreak), .out_ecall(out_ecall), .out_mret(out_mret),
    .out_illegal(out_illegal), .count(count)
  );

  ysyx_23060061_idu #(.XLEN(32), .FIFO_DEPTH(2), .NREG(16)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(e_out_valid), .out_ready(out_ready),
    .out_pc(e_pc), .out_inst_type(e_inst_type), .out_rs1(e_rs1), .out_rs2(e_rs2),
    .out_rd(e_rd), .out_imm(e_imm), .out_reg_write(e_reg_write), .out_mem_rw(e_mem_rw),
    .out_mem_size(e_mem_size), .out_mem_unsigned(e_mem_unsigned), .out_branch(e_branch),
    .out_br_cond(e_br_cond), .out_jump(e_jump), .out_alu_a_sel(e_a_sel),
    .out_alu_b_sel(e_b_sel), .out_alu_op(e_alu_op), .out_wb_sel(e_wb_sel),
    .out_ebreak(e_ebreak), .out_ecall(e_ecall), .out_mret(e_mret),
    .out_illegal(e_illegal), .count(e_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction for one edge; inputs change on the falling edge.
  task automatic push1(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0050_0093; in_pc = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_imm", out_imm, 0);
    chk("rst_reg_write", 32'(out_reg_write), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // addi x1,x0,5
    push1(32'h0050_0093, 32'h8000_0000);
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_imm", out_imm, 5);
    chk("addi_alu_op", 32'(out_alu_op), 0);
    chk("addi_reg_write", 32'(out_reg_write), 1);
    chk("addi_b_sel", 32'(out_alu_b_sel), 1);
    chk("addi_rd", 32'(out_rd), 1);
    chk("addi_type", 32'(out_inst_type), 2);
    chk("addi_pc", out_pc, 32'h8000_0000);
    chk("addi_count", 32'(count), 1);

    // Fill with out_ready=0: sw then lbu offered while full.
    push1(32'h0020_A223, 32'h8000_0004);
    chk("full_count", 32'(count), 2);
    chk("full_in_ready", 32'(in_ready), 0);
    push1(32'h0030_C283, 32'h8000_0008);
    chk("blocked_count", 32'(count), 2);
    chk("hold_pc", out_pc, 32'h8000_0000);
    chk("hold_imm", out_imm, 5);

    // Pop addi -> head is sw x2,4(x1)
    pop1();
    chk("sw_mem_rw", 32'(out_mem_rw), 32'b01);
    chk("sw_size", 32'(out_mem_size), 32'b10);
    chk("sw_imm", out_imm, 4);
    chk("sw_reg_write", 32'(out_reg_write), 0);
    chk("sw_rs1_rs2", {27'd0, out_rs1} * 32 + 32'(out_rs2), 32'd34);
    chk("sw_count", 32'(count), 1);

    // Pop sw while pushing lbu x5,3(x1): count stays 1.
    out_ready = 1'b1;
    push1(32'h0030_C283, 32'h8000_0008);
    out_ready = 1'b0;
    chk("pp_count", 32'(count), 1);
    chk("lbu_mem_rw", 32'(out_mem_rw), 32'b10);
    chk("lbu_unsigned", 32'(out_mem_unsigned), 1);
    chk("lbu_wb_sel", 32'(out_wb_sel), 32'b01);
    chk("lbu_size", 32'(out_mem_size), 0);
    chk("lbu_imm", out_imm, 3);
    pop1();
    chk("drain_valid", 32'(out_valid), 0);

    // bne x1,x2,+8
    push1(32'h0020_9463, 32'h8000_0010);
    chk("bne_branch", 32'(out_branch), 1);
    chk("bne_cond", 32'(out_br_cond), 1);
    chk("bne_imm", out_imm, 8);
    chk("bne_type", 32'(out_inst_type), 4);
    chk("bne_reg_write", 32'(out_reg_write), 0);
    pop1();

    // jalr x1,0(x5)
    push1(32'h0002_80E7, 32'h8000_0014);
    chk("jalr_alu_op", 32'(out_alu_op), 11);
    chk("jalr_wb_sel", 32'(out_wb_sel), 2);
    chk("jalr_jump", 32'(out_jump), 1);
    pop1();

    // lui x3,0x12345
    push1(32'h1234_51B7, 32'h8000_0018);
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_alu_op", 32'(out_alu_op), 10);
    pop1();

    // Fill, then flush while full with an instruction offered.
    push1(32'h0050_0093, 32'h9000_0000);
    push1(32'h0050_0093, 32'h9000_0004);
    chk("pre_flush_count", 32'(count), 2);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h9000_0008;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_imm_forced", out_imm, 0);
    @(negedge clk);
    chk("flush_dropped", 32'(count), 0);

    // Illegal all-ones, then addi x17,x0,1 (legal for NREG=32, illegal for NREG=16).
    push1(32'hFFFF_FFFF, 32'hA000_0000);
    chk("ones_illegal", 32'(out_illegal), 1);
    chk("ones_reg_write", 32'(out_reg_write), 0);
    chk("ones_mem_rw", 32'(out_mem_rw), 0);
    out_ready = 1'b1;
    push1(32'h0010_0893, 32'hA000_0004);
    out_ready = 1'b0;
    chk("x17_illegal_rv32i", 32'(out_illegal), 0);
    chk("x17_rd_rv32i", 32'(out_rd), 17);
    chk("x17_illegal_rv32e", 32'(e_illegal), 1);
    chk("x17_reg_write_rv32e", 32'(e_reg_write), 0);
    chk("x17_mem_rw_rv32e", 32'(e_mem_rw), 0);
    pop1();

    // ebreak
    push1(32'h0010_0073, 32'hA000_0008);
    chk("ebreak_flag", 32'(out_ebreak), 1);
    chk("ebreak_illegal", 32'(out_illegal), 0);
    chk("ebreak_reg_write", 32'(out_reg_write), 0);
    pop1();

    // ecall: legal only with the CSR extension.
    push1(32'h0000_0073, 32'hA000_000C);
    chk("ecall_flag", 32'(out_ecall), 32'(ZICSR));
    chk("ecall_illegal", 32'(out_illegal), 32'(!ZICSR));
    pop1();
    chk("empty_count", 32'(count), 0);

    // Stream 16 back-to-back across pointer wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_inst  = (32'(i) << 20) | 32'h0000_0093;
      in_pc    = 32'h0000_1000 + 32'(4 * i);
      @(negedge clk);
      chk($sformatf("stream_pc_%0d", i), out_pc, 32'h0000_1000 + 32'(4 * i));
      chk($sformatf("stream_imm_%0d", i), out_imm, 32'(i));
      chk($sformatf("stream_count_%0d", i), 32'(count), 1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stream_end_count", 32'(count), 0);
    chk("stream_end_valid", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_23060061_idu.md
# ysyx_23060061_idu

Instruction decode unit with a parametrised instruction queue, replacing the single-cycle combinational decoder. It accepts fetched instruction/PC pairs over a valid/ready handshake and buffers them in a small FIFO. It decodes the head entry for the full RV32I base set (RV32E optional), including branches, sized loads/stores and illegal-instruction detection. It presents the decoded control bundle to the execute stage over a second valid/ready handshake, and sits between IFU and EXU.

## Interface
- `XLEN`, 32: datapath width; sets the width of immediates and PCs.
- `FIFO_DEPTH`, 2: queue entries; a power of two, ≥2.
- `NREG`, 32: architectural register count, 32 or 16. With 16, any rs1/rs2/rd index ≥16 flags illegal.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous; discards all queued entries.
- `in_valid`  in  1  IFU offers an instruction.
- `in_ready`  out  1  queue can accept.
- `in_inst`  in  32  raw instruction.
- `in_pc`  in  XLEN  instruction PC.
- `out_valid`  out  1  decoded head entry valid.
- `out_ready`  in  1  EXU consumes the head.
- `out_pc`  out  XLEN  PC of the head entry.
- `out_inst_type`  out  3  R/I/S/B/U/J, encoded per shared constants.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices.
- `out_imm`  out  XLEN  sign-extended immediate.
- `out_reg_write`  out  1  register write enable; forced 0 when rd==0.
- `out_mem_rw`  out  2  00 idle, 10 read, 01 write.
- `out_mem_size`  out  2  00 byte, 01 half, 10 word.
- `out_mem_unsigned`  out  1  LBU/LHU.
- `out_branch`  out  1  conditional branch.
- `out_br_cond`  out  3  branch funct3, passed through.
- `out_jump`  out  1  JAL/JALR.
- `out_alu_a_sel`, `out_alu_b_sel`  out  1 each  A: 0 rs1 / 1 PC. B: 0 rs2 / 1 imm.
- `out_alu_op`  out  4  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 passB, 11 add-clear-LSB.
- `out_wb_sel`  out  2  00 ALU, 01 memory, 10 PC+4, 11 CSR.
- `out_ebreak`, `out_ecall`, `out_mret`  out  1 each  system events.
- `out_illegal`  out  1  unknown or disallowed encoding.
- `count`  out  $clog2(FIFO_DEPTH)+1  queue occupancy.

## Operation
- The queue holds {inst, pc}.
- Push: `in_valid && in_ready`. `in_ready = !full`. There is no combinational ready path from `out_ready`.
- Pop: `out_valid && out_ready`. `out_valid = !empty`.
- Decode is combinational from the registered head entry. All `out_*` fields except `out_valid` are forced to 0 while empty.
- Simultaneous push and pop when non-empty and not full: count unchanged, both pointers advance.
- When full, push is blocked even if a pop occurs in the same cycle.
- `flush` has priority over push and pop. Next cycle: count=0 and `out_valid`=0, and the instruction offered during the flush cycle is dropped.
- Pointers wrap modulo `FIFO_DEPTH`.
- Illegal encodings: unknown opcode, bad funct3/funct7, or a register index ≥`NREG`. These set `out_illegal`=1 with `out_reg_write`=0 and `out_mem_rw`=00; the entry still pops normally.
- `ebreak` = 0x00100073 exactly. It sets `out_ebreak`, with no register or memory write.
- `jalr` uses alu_op 11 (add-clear-LSB), wb_sel 10. `lui` uses passB. `auipc` uses A=PC, B=imm, add.

## Timing
- Reset (asynchronous assert, synchronous deassert by system): count=0, `out_valid`=0, `in_ready`=1, all decoded outputs 0. Reset during any operation empties the queue immediately.
- Latency: an instruction accepted at edge N is presented with `out_valid`=1 in the cycle after edge N, if the queue was empty.
- Throughput is one instruction per cycle in steady state, given `FIFO_DEPTH` ≥2.
- Handshake rule: head outputs hold stable while `out_valid && !out_ready`.

## Configuration
- `YSYX_23060061_ZICSR_EN` defined: CSRRW/S/C and their immediate forms decode with wb_sel 11. ECALL (0x00000073) sets `out_ecall`, and MRET (0x30200073) sets `out_mret`.
- Undefined: in opcode 1110011, only EBREAK is legal; every other encoding sets `out_illegal`. `out_ecall` and `out_mret` are tied to 0.

## Structure
- The existing shared header `global.vh` holds: opcode constants, instruction-type encodings (extended with the full type set), the ALU-op encodings, and the wb_sel/mem_size encodings.
- Sub-module `ysyx_23060061_inst_fifo`: parametrised width/depth synchronous FIFO with flush and count. The decode logic lives in the top module.

## Test plan
- Reset, then push `addi x1,x0,5` (0x00500093): one cycle later `out_valid`=1, imm=5, alu_op=0, reg_write=1, B=imm.
- Hold `out_ready`=0 and push 3 instructions with `FIFO_DEPTH`=2: `in_ready` drops after 2, head stays stable, count=2.
- Stream 16 back-to-back instructions with `out_ready`=1: one pop per cycle, PCs in order across pointer wrap.
- `sw` 0x0020A223 → mem_rw=01, size=10, imm=4, reg_write=0. `lbu` → mem_rw=10, unsigned=1, wb_sel=01.
- 0xFFFFFFFF and, with `NREG`=16, `addi x17,x0,1` → `out_illegal`=1 with no writes. `flush` while full → count=0 next cycle.
- ECALL with and without the macro → `out_ecall`=1 versus `out_illegal`=1.
